rx_frame_decoder: RTL and testbench
===================================

RX_FRAME_DECODER -- requirements
Module: rx_frame_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bus data width in bits, a multiple of 8, range 8..32.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning bus address width in bits, a multiple of 8, range 8..16.
REQ-003 SHALL have parameter HDR_WR, default 8'h80, meaning the header byte that opens a write frame.
REQ-004 SHALL have parameter HDR_RD, default 8'h81, meaning the header byte that opens a read frame.
REQ-005 SHALL have parameter TMO_CYC, default 16'd50000, meaning the inter-byte timeout in clk_i cycles.
REQ-006 SHALL have the port clk_i, in, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have the port rst_i, in, 1, an asynchronous, active-low reset.
REQ-008 SHALL have the port rx_byte_i, in, 8, the received UART byte, valid when rx_vld_i is high.
REQ-009 SHALL have the port rx_vld_i, in, 1, a one-cycle strobe per received byte.
REQ-010 SHALL have the ports io_stb_o (out, 1) and io_we_o (out, 1), the bus strobe and write-enable.
REQ-011 SHALL have the ports io_adr_o (out, ADDR_W) and io_dat_o (out, DATA_W), the bus address and write data.
REQ-012 SHALL have the ports io_dat_i (in, DATA_W) and io_ack_i (in, 1), the bus read data and acknowledge.
REQ-013 SHALL have the ports rd_dat_o (out, DATA_W) and rd_vld_o (out, 1), the captured read data and its one-cycle valid.
REQ-014 SHALL have the ports err_hdr_o, err_ovf_o and err_tmo_o (out, 1 each), one-cycle error pulses.
REQ-015 SHALL have the port frame_cnt_o, out, 8, the count of completed bus transactions.

Function
REQ-016 SHALL implement the states IDLE, ADDR, DATA and ISSUE.
REQ-017 SHALL, in IDLE on a rx_vld_i byte equal to HDR_WR or HDR_RD, latch the direction and go to ADDR.
REQ-018 SHALL, in IDLE on any other byte, stay in IDLE and pulse err_hdr_o for one cycle.
REQ-019 SHALL, in ADDR, shift in ADDR_W/8 bytes MSB-first; after the last byte go to DATA for a write or to ISSUE for a read.
REQ-020 SHALL, in DATA, shift in DATA_W/8 bytes MSB-first and go to ISSUE after the last byte.
REQ-021 SHALL use an internal byte counter that is cleared on every state entry.
REQ-022 SHALL assert io_stb_o in the cycle after the final byte's rx_vld_i cycle, with io_we_o set to 1 for a write and 0 for a read.
REQ-023 SHALL hold io_adr_o and io_dat_o stable throughout ISSUE.
REQ-024 SHALL hold io_stb_o high until io_ack_i is sampled high; in that same edge it returns to IDLE, and io_stb_o is low in the next cycle.
REQ-025 SHALL, on ack of a read, capture io_dat_i into rd_dat_o and pulse rd_vld_o for one cycle.
REQ-026 SHALL hold rd_dat_o until the next read ack.
REQ-027 SHALL increment frame_cnt_o by 1 on every ack, wrapping from 255 to 0.
REQ-028 SHALL, when a rx_vld_i byte arrives during ISSUE, drop the byte and pulse err_ovf_o; the transaction continues unaffected.
REQ-029 SHALL, when rx_vld_i and io_ack_i coincide in ISSUE, complete the ack and treat the byte as an overflow, not as a header.
REQ-030 SHALL ignore io_ack_i outside ISSUE.

Reset
REQ-031 SHALL, while rst_i is low, immediately force the state to IDLE.
REQ-032 SHALL, while rst_i is low, force all outputs, the counters and the shift registers to 0, including a reset asserted mid-frame or mid-ISSUE.
REQ-033 SHALL, after rst_i releases, accept a header on the first rx_vld_i.

Configuration
REQ-034 SHALL, with RXDEC_TIMEOUT_EN defined, count clk_i cycles in ADDR/DATA since the last rx_vld_i.
REQ-035 SHALL, on that count reaching TMO_CYC, discard the partial frame, return to IDLE and pulse err_tmo_o.
REQ-036 SHALL never apply the timeout in ISSUE.
REQ-037 SHALL, without RXDEC_TIMEOUT_EN, wait indefinitely in ADDR/DATA, tie err_tmo_o to 0, and contain no timeout counter.

Structure
REQ-038 SHALL use a shared package rxdec_pkg for the state enum, the default HDR_WR/HDR_RD constants and the error-bit index constants.
REQ-039 SHALL place the timeout counter in the sub-module rxdec_timeout (inputs: clear, enable; output: expired), instantiated only under RXDEC_TIMEOUT_EN.

Verification
REQ-040 SHALL verify a write with defaults: bytes 80,12,AB,CD -> one cycle later stb=1, we=1, adr=12, dat=ABCD; ack after 3 cycles -> stb low the next cycle, frame_cnt=1.
REQ-041 SHALL verify a read: bytes 81,34 with io_dat_i=BEEF on ack -> we=0, adr=34, rd_dat=BEEF, one rd_vld pulse.
REQ-042 SHALL verify a bad header and overflow: byte 55 in IDLE -> err_hdr pulse, state IDLE; a byte 80 during an unacked ISSUE -> err_ovf pulse, adr/dat unchanged.
REQ-043 SHALL verify a timeout under RXDEC_TIMEOUT_EN with TMO_CYC=10: bytes 80,12 then 10 idle cycles -> err_tmo pulse; then bytes 81,07 -> a read issued at adr=07.
REQ-044 SHALL verify reset and counter wrap: rst_i low during DATA -> all outputs 0 at once; 256 acked frames -> frame_cnt wraps to 0.
REQ-045 SHALL verify wide parameters: DATA_W=32 and ADDR_W=16 with bytes 80,01,02,DE,AD,BE,EF -> adr=0102, dat=DEADBEEF.

Source files
------------

// File: rtl/rxdec_pkg.sv
// Shared state encoding, header defaults and error-bit indices for the
// UART-to-bus frame decoder.
package rxdec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } rxdec_state_e;

  localparam logic [7:0] HDR_WR_DEFAULT = 8'h80;
  localparam logic [7:0] HDR_RD_DEFAULT = 8'h81;

  localparam int ERR_HDR = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_TMO = 2;
  localparam int ERR_NUM = 3;

  function automatic int bytes_in(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/rxdec_timeout.sv
// Inter-byte timeout counter for the frame decoder; counts enabled cycles
// since the last clear and flags the cycle on which TMO_CYC is reached.
module rxdec_timeout
  import rxdec_pkg::*;
#(
  parameter logic [15:0] TMO_CYC = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clear || !enable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // The edge that would make the count equal TMO_CYC is the expiry edge.
  assign expired = enable && !clear && (cnt_q == TMO_CYC - 16'd1);

endmodule

// File: rtl/rx_frame_decoder.sv
// Decodes UART byte frames (header, address, optional data) into single bus
// transactions. Define RXDEC_TIMEOUT_EN to abort stalled frames after TMO_CYC.
module rx_frame_decoder
  import rxdec_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter logic [7:0]  HDR_WR  = HDR_WR_DEFAULT,
  parameter logic [7:0]  HDR_RD  = HDR_RD_DEFAULT,
  parameter logic [15:0] TMO_CYC = 16'd50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_vld_i,
  output logic              io_stb_o,
  output logic              io_we_o,
  output logic [ADDR_W-1:0] io_adr_o,
  output logic [DATA_W-1:0] io_dat_o,
  input  logic [DATA_W-1:0] io_dat_i,
  input  logic              io_ack_i,
  output logic [DATA_W-1:0] rd_dat_o,
  output logic              rd_vld_o,
  output logic              err_hdr_o,
  output logic              err_ovf_o,
  output logic              err_tmo_o,
  output logic [7:0]        frame_cnt_o
);

  localparam logic [1:0] ADDR_LAST = 2'(bytes_in(ADDR_W) - 1);
  localparam logic [1:0] DATA_LAST = 2'(bytes_in(DATA_W) - 1);
`ifdef RXDEC_TIMEOUT_EN
  localparam int ERR_BITS = ERR_NUM;
`else
  localparam int ERR_BITS = ERR_NUM - 1;
`endif

  rxdec_state_e        state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d, adr_shift;
  logic [DATA_W-1:0]   dat_q, dat_d, dat_shift;
  logic [DATA_W-1:0]   rd_dat_q, rd_dat_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ERR_BITS-1:0] err_q, err_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  // Byte-wide MSB-first shift; the narrowest widths are a plain load.
  if (ADDR_W > 8) begin : g_adr_shift
    assign adr_shift = {adr_q[ADDR_W-9:0], rx_byte_i};
  end else begin : g_adr_load
    assign adr_shift = rx_byte_i;
  end

  if (DATA_W > 8) begin : g_dat_shift
    assign dat_shift = {dat_q[DATA_W-9:0], rx_byte_i};
  end else begin : g_dat_load
    assign dat_shift = rx_byte_i;
  end

`ifdef RXDEC_TIMEOUT_EN
  logic tmo_enable;
  logic tmo_expired;

  assign tmo_enable = (state_q == ADDR) || (state_q == DATA);

  rxdec_timeout #(
    .TMO_CYC (TMO_CYC)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (rx_vld_i),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rd_dat_q    <= '0;
      rd_vld_q    <= 1'b0;
      err_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rd_dat_q    <= rd_dat_d;
      rd_vld_q    <= rd_vld_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rd_dat_d    = rd_dat_q;
    rd_vld_d    = 1'b0;
    err_d       = '0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (rx_vld_i) begin
          if (rx_byte_i == HDR_WR || rx_byte_i == HDR_RD) begin
            we_d    = (rx_byte_i == HDR_WR);
            state_d = ADDR;
          end else begin
            err_d[ERR_HDR] = 1'b1;
          end
        end
      end

      ADDR: begin
        if (rx_vld_i) begin
          adr_d = adr_shift;
          if (byte_cnt_q == ADDR_LAST) begin
            byte_cnt_d = '0;
            state_d    = we_q ? DATA : ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
`ifdef RXDEC_TIMEOUT_EN
        else if (tmo_expired) begin
          byte_cnt_d     = '0;
          state_d        = IDLE;
          err_d[ERR_TMO] = 1'b1;
        end
`endif
      end

      DATA: begin
        if (rx_vld_i) begin
          dat_d = dat_shift;
          if (byte_cnt_q == DATA_LAST) begin
            byte_cnt_d = '0;
            state_d    = ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
`ifdef RXDEC_TIMEOUT_EN
        else if (tmo_expired) begin
          byte_cnt_d     = '0;
          state_d        = IDLE;
          err_d[ERR_TMO] = 1'b1;
        end
`endif
      end

      ISSUE: begin
        // A byte here is always an overflow, even on the ack edge.
        if (rx_vld_i) begin
          err_d[ERR_OVF] = 1'b1;
        end
        if (io_ack_i) begin
          byte_cnt_d  = '0;
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (!we_q) begin
            rd_dat_d = io_dat_i;
            rd_vld_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io_stb_o    = (state_q == ISSUE);
  assign io_we_o     = we_q && (state_q == ISSUE);
  assign io_adr_o    = adr_q;
  assign io_dat_o    = dat_q;
  assign rd_dat_o    = rd_dat_q;
  assign rd_vld_o    = rd_vld_q;
  assign err_hdr_o   = err_q[ERR_HDR];
  assign err_ovf_o   = err_q[ERR_OVF];
  assign frame_cnt_o = frame_cnt_q;
`ifdef RXDEC_TIMEOUT_EN
  assign err_tmo_o   = err_q[ERR_TMO];
`else
  assign err_tmo_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Self-checking bench for rx_frame_decoder: a default-width instance with a
// short timeout and a 32-bit data / 16-bit address instance.
module tb_rx_frame_decoder;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [15:0] dat;
    logic [15:0] rdat;
  } txn_t;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [15:0] dat;
    logic [15:0] rdat;
    int          delay;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_vld = 1'b0;

  logic        stb, we, ack = 1'b0, rd_vld, err_hdr, err_ovf, err_tmo;
  logic [7:0]  adr, frame_cnt;
  logic [15:0] dat_o, dat_in = 16'h0000, rd_dat;

  logic        w_rx_vld = 1'b0, w_ack = 1'b0;
  logic        w_stb, w_we, w_rd_vld, w_err_hdr, w_err_ovf, w_err_tmo;
  logic [15:0] w_adr;
  logic [31:0] w_dat_o, w_dat_in = 32'h0, w_rd_dat;
  logic [7:0]  w_frame_cnt;

  txn_t        exp_q[$];
  logic [15:0] rd_exp_q[$];
  txn_t        mon_t;
  logic [15:0] mon_rd;
  vec_t        vecs[6];

  int num_checks = 0, num_fail = 0;
  int n_hdr = 0, n_ovf = 0, n_tmo = 0, n_rdv = 0;
  int exp_frames = 0, wait_cnt = 0, ack_delay = 0, stb_len = 0;
  bit ack_en = 1'b0, ack_check = 1'b0;

  always #5 clk = ~clk;

  rx_frame_decoder #(
    .TMO_CYC (16'd10)
  ) dut (
    .clk_i (clk), .rst_i (rst_n), .rx_byte_i (rx_byte), .rx_vld_i (rx_vld),
    .io_stb_o (stb), .io_we_o (we), .io_adr_o (adr), .io_dat_o (dat_o),
    .io_dat_i (dat_in), .io_ack_i (ack), .rd_dat_o (rd_dat), .rd_vld_o (rd_vld),
    .err_hdr_o (err_hdr), .err_ovf_o (err_ovf), .err_tmo_o (err_tmo),
    .frame_cnt_o (frame_cnt)
  );

  rx_frame_decoder #(
    .DATA_W (32),
    .ADDR_W (16)
  ) dut_wide (
    .clk_i (clk), .rst_i (rst_n), .rx_byte_i (rx_byte), .rx_vld_i (w_rx_vld),
    .io_stb_o (w_stb), .io_we_o (w_we), .io_adr_o (w_adr), .io_dat_o (w_dat_o),
    .io_dat_i (w_dat_in), .io_ack_i (w_ack), .rd_dat_o (w_rd_dat), .rd_vld_o (w_rd_vld),
    .err_hdr_o (w_err_hdr), .err_ovf_o (w_err_ovf), .err_tmo_o (w_err_tmo),
    .frame_cnt_o (w_frame_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    num_checks++;
    num_fail++;
    $display("[TB] FAIL %s: event not expected at this point", name);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_byte = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic applyWide(input logic [7:0] b);
    rx_byte  = b;
    w_rx_vld = 1'b1;
    @(negedge clk);
    w_rx_vld = 1'b0;
  endtask

  task automatic sendFrame(input logic w, input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] rd);
    txn_t t;
    t.we = w; t.adr = a; t.dat = d; t.rdat = rd;
    exp_q.push_back(t);
    if (!w) rd_exp_q.push_back(rd);
    applyStimulus(w ? 8'h80 : 8'h81);
    applyStimulus(a);
    if (w) begin
      applyStimulus(d[15:8]);
      applyStimulus(d[7:0]);
    end
  endtask

  // Counts stb cycles until the transaction retires, bounded.
  task automatic waitIdle(output int n);
    n = 0;
    while (stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (stb) failNow("stb_stuck");
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stb"}, stb, 0);
    checkOutput({tag, "_we"}, we, 0);
    checkOutput({tag, "_adr"}, adr, 0);
    checkOutput({tag, "_dat"}, dat_o, 0);
    checkOutput({tag, "_rd_dat"}, rd_dat, 0);
    checkOutput({tag, "_rd_vld"}, rd_vld, 0);
    checkOutput({tag, "_errs"}, {err_hdr, err_ovf, err_tmo}, 0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // Bus responder and scoreboard: acks after ack_delay stb cycles and checks
  // each issued transaction and each read result against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack        = 1'b0;
      wait_cnt   = 0;
      ack_check  = 1'b0;
      exp_frames = 0;
      exp_q.delete();
      rd_exp_q.delete();
    end else begin
      if (ack_check) begin
        checkOutput("stb_drop", stb, 0);
        ack_check = 1'b0;
      end
      if (rd_vld) begin
        n_rdv++;
        if (rd_exp_q.size() == 0) failNow("rd_vld_unexpected");
        else begin
          mon_rd = rd_exp_q.pop_front();
          checkOutput("rd_dat", rd_dat, mon_rd);
        end
      end
      if (err_hdr) n_hdr++;
      if (err_ovf) n_ovf++;
      if (err_tmo) n_tmo++;
      if (ack) begin
        ack      = 1'b0;
        wait_cnt = 0;
      end else if (stb && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          if (exp_q.size() == 0) failNow("txn_unexpected");
          else begin
            mon_t = exp_q.pop_front();
            checkOutput("bus_we", we, mon_t.we);
            checkOutput("bus_adr", adr, mon_t.adr);
            if (mon_t.we) checkOutput("bus_dat", dat_o, mon_t.dat);
            dat_in = mon_t.rdat;
          end
          ack        = 1'b1;
          ack_check  = 1'b1;
          exp_frames = (exp_frames + 1) % 256;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h01, 16'h0001, 16'h0000, 0};
    vecs[1] = '{1'b0, 8'h02, 16'h0000, 16'hFFFF, 1};
    vecs[2] = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000, 2};
    vecs[3] = '{1'b0, 8'h80, 16'h0000, 16'h0000, 0};
    vecs[4] = '{1'b1, 8'h00, 16'h8001, 16'h0000, 5};
    vecs[5] = '{1'b0, 8'h5A, 16'h0000, 16'hA5C3, 0};

    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write frame, acked after 3 stb cycles.
    ack_en = 1'b1; ack_delay = 3;
    sendFrame(1'b1, 8'h12, 16'hABCD, 16'h0000);
    checkOutput("wr_stb", stb, 1);
    checkOutput("wr_we", we, 1);
    checkOutput("wr_adr", adr, 8'h12);
    checkOutput("wr_dat", dat_o, 16'hABCD);
    waitIdle(stb_len);
    checkOutput("wr_stb_len", stb_len, 4);
    checkOutput("wr_frame_cnt", frame_cnt, 1);

    // Read frame.
    ack_delay = 1;
    sendFrame(1'b0, 8'h34, 16'h0000, 16'hBEEF);
    checkOutput("rd_stb", stb, 1);
    checkOutput("rd_we", we, 0);
    checkOutput("rd_adr", adr, 8'h34);
    waitIdle(stb_len);
    checkOutput("rd_result", rd_dat, 16'hBEEF);
    checkOutput("rd_pulses", n_rdv, 1);
    repeat (3) @(negedge clk);
    checkOutput("rd_vld_single", rd_vld, 0);
    checkOutput("rd_hold", rd_dat, 16'hBEEF);

    // Bad header.
    applyStimulus(8'h55);
    checkOutput("hdr_pulse", err_hdr, 1);
    checkOutput("hdr_no_stb", stb, 0);
    @(negedge clk);
    checkOutput("hdr_single", err_hdr, 0);

    for (int i = 0; i < 6; i++) begin
      ack_delay = vecs[i].delay;
      sendFrame(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].rdat);
      checkOutput($sformatf("vec%0d_stb", i), stb, 1);
      checkOutput($sformatf("vec%0d_adr", i), adr, vecs[i].adr);
      waitIdle(stb_len);
      checkOutput($sformatf("vec%0d_len", i), stb_len, vecs[i].delay + 1);
      if (!vecs[i].we) checkOutput($sformatf("vec%0d_rd", i), rd_dat, vecs[i].rdat);
      checkOutput($sformatf("vec%0d_cnt", i), frame_cnt, exp_frames);
    end

    // Overflow during an unacked ISSUE, then a byte coinciding with the ack.
    ack_en = 1'b0;
    sendFrame(1'b1, 8'h56, 16'h1234, 16'h0000);
    checkOutput("ovf_stb_pre", stb, 1);
    applyStimulus(8'h80);
    checkOutput("ovf_pulse", err_ovf, 1);
    checkOutput("ovf_stb", stb, 1);
    checkOutput("ovf_adr", adr, 8'h56);
    checkOutput("ovf_dat", dat_o, 16'h1234);
    checkOutput("ovf_no_hdr", err_hdr, 0);
    #1;
    ack_delay = 0; ack_en = 1'b1;
    @(negedge clk);
    applyStimulus(8'h80);
    checkOutput("coin_ovf", err_ovf, 1);
    checkOutput("coin_stb", stb, 0);
    checkOutput("coin_cnt", frame_cnt, exp_frames);
    sendFrame(1'b0, 8'h9A, 16'h0000, 16'h1357);
    checkOutput("coin_idle_stb", stb, 1);
    checkOutput("coin_idle_adr", adr, 8'h9A);
    waitIdle(stb_len);
    checkOutput("ovf_count", n_ovf, 2);
    checkOutput("hdr_count", n_hdr, 1);

`ifdef RXDEC_TIMEOUT_EN
    applyStimulus(8'h80);
    applyStimulus(8'h12);
    repeat (9) @(negedge clk);
    checkOutput("tmo_early", err_tmo, 0);
    @(negedge clk);
    checkOutput("tmo_pulse", err_tmo, 1);
    checkOutput("tmo_stb", stb, 0);
    sendFrame(1'b0, 8'h07, 16'h0000, 16'h5A5A);
    checkOutput("tmo_rd_stb", stb, 1);
    checkOutput("tmo_rd_we", we, 0);
    checkOutput("tmo_rd_adr", adr, 8'h07);
    waitIdle(stb_len);
    checkOutput("tmo_rd_dat", rd_dat, 16'h5A5A);
`else
    checkOutput("tmo_never", n_tmo, 0);
`endif

    // Reset mid-DATA, then mid-ISSUE.
    applyStimulus(8'h80);
    applyStimulus(8'h12);
    applyStimulus(8'hAB);
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst_data");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    applyStimulus(8'h80);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    checkOutput("rst_issue_pre", stb, 1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst_issue");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_en = 1'b1; ack_delay = 0;
    sendFrame(1'b0, 8'h21, 16'h0000, 16'h0F0F);
    checkOutput("post_rst_stb", stb, 1);
    waitIdle(stb_len);
    checkOutput("post_rst_rd", rd_dat, 16'h0F0F);
    checkOutput("post_rst_cnt", frame_cnt, 1);

    // Frame counter wrap.
    for (int i = 1; i < 256; i++) begin
      sendFrame(1'b1, 8'(i), 16'(i * 3), 16'h0000);
      waitIdle(stb_len);
      if (i == 254) checkOutput("wrap_255", frame_cnt, 255);
    end
    checkOutput("wrap_0", frame_cnt, 0);

    // Wide instance.
    applyWide(8'h80);
    applyWide(8'h01);
    applyWide(8'h02);
    applyWide(8'hDE);
    applyWide(8'hAD);
    applyWide(8'hBE);
    applyWide(8'hEF);
    checkOutput("wide_stb", w_stb, 1);
    checkOutput("wide_we", w_we, 1);
    checkOutput("wide_adr", w_adr, 16'h0102);
    checkOutput("wide_dat", w_dat_o, 32'hDEADBEEF);
    w_ack = 1'b1;
    @(negedge clk);
    w_ack = 1'b0;
    checkOutput("wide_stb_drop", w_stb, 0);
    checkOutput("wide_cnt", w_frame_cnt, 1);
    checkOutput("wide_quiet", {w_rd_vld, w_err_hdr, w_err_ovf, w_err_tmo}, 0);
    checkOutput("wide_rd_dat", w_rd_dat, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
